// File: rtl/layer_compositor.sv
// layer_compositor
//   Per-pixel priority compositor for the VGA path. Chooses the lowest-index
//   opaque, enabled layer that requests drawing, otherwise the background
//   colour, through a two-stage registered pipeline (input latency 2 clocks).
//   Also accumulates per-layer overlap flags over a frame and publishes them
//   on each start-of-frame.
//
// Ports
//   clk                  pixel clock
//   resetN               asynchronous active-low reset
//   pixelValid           inputs describe a visible pixel
//   startOfFrame         one-cycle pulse on the first pixel of a frame
//   layerEnable          per-layer runtime enable
//   layerDR              per-layer drawing request
//   layerRGB             per-layer colour, packed [LAYERS-1:0][COLOR_W-1:0]
//   backGroundRGB        colour used when no layer wins
//   RGBOut               composited colour
//   RGBValid             RGBOut belongs to a valid pixel
//   winnerIdx            index of the winning layer (0 when none)
//   winnerValid          a layer, not the background, produced RGBOut
//   frameCollision       per-layer collision flags of the previous frame
//   frameCollisionStrobe one-cycle pulse when frameCollision is updated
module layer_compositor #(
    parameter int                 LAYERS      = 8,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 8'hFF,
    parameter int                 IDX_W       = $clog2(LAYERS)
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            pixelValid,
    input  logic                            startOfFrame,
    input  logic [LAYERS-1:0]               layerEnable,
    input  logic [LAYERS-1:0]               layerDR,
    input  logic [LAYERS-1:0][COLOR_W-1:0]  layerRGB,
    input  logic [COLOR_W-1:0]              backGroundRGB,
    output logic [COLOR_W-1:0]              RGBOut,
    output logic                            RGBValid,
    output logic [IDX_W-1:0]                winnerIdx,
    output logic                            winnerValid,
    output logic [LAYERS-1:0]               frameCollision,
    output logic                            frameCollisionStrobe
);

    // Stage 0: effective requests and collision contribution
    logic [LAYERS-1:0] eff;
    logic              multi_hit;
    logic [LAYERS-1:0] contrib;

    // Stage 1 registers
    logic [LAYERS-1:0]              s1_eff_q,   s1_eff_d;
    logic [LAYERS-1:0][COLOR_W-1:0] s1_rgb_q,   s1_rgb_d;
    logic [COLOR_W-1:0]             s1_bg_q,    s1_bg_d;
    logic                           s1_valid_q, s1_valid_d;

    // Stage 2 registers (outputs)
    logic [COLOR_W-1:0] rgb_out_q,   rgb_out_d;
    logic               rgb_valid_q, rgb_valid_d;
    logic [IDX_W-1:0]   win_idx_q,   win_idx_d;
    logic               win_valid_q, win_valid_d;

    // Collision tracking
    logic [LAYERS-1:0] acc_q,       acc_d;
    logic [LAYERS-1:0] frame_col_q, frame_col_d;
    logic              strobe_q,    strobe_d;

    // Priority search over stage-1 requests
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [COLOR_W-1:0] win_rgb;

    always_comb begin
        eff = '0;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            eff[i] = layerDR[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT);
        end
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_hit = |(eff & (eff - LAYERS'(1)));
        contrib   = (pixelValid && multi_hit) ? eff : '0;
    end

    always_comb begin
        s1_eff_d   = eff;
        s1_rgb_d   = layerRGB;
        s1_bg_d    = backGroundRGB;
        s1_valid_d = pixelValid;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rgb   = s1_bg_q;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            if (!win_found && s1_eff_q[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = s1_rgb_q[i];
            end
        end
    end

    always_comb begin
        rgb_out_d   = rgb_out_q;
        win_idx_d   = win_idx_q;
        win_valid_d = win_valid_q;
        rgb_valid_d = s1_valid_q;
        // A bubble holds the last composited pixel on the outputs.
        if (s1_valid_q) begin
            rgb_out_d   = win_rgb;
            win_idx_d   = win_idx;
            win_valid_d = win_found;
        end
    end

    always_comb begin
        frame_col_d = frame_col_q;
        strobe_d    = startOfFrame;
        acc_d       = acc_q | contrib;
        // The start-of-frame cycle already belongs to the new frame, so its
        // own contribution seeds the fresh accumulator instead of the report.
        if (startOfFrame) begin
            frame_col_d = acc_q;
            acc_d       = contrib;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_eff_q    <= '0;
            s1_rgb_q    <= '0;
            s1_bg_q     <= '0;
            s1_valid_q  <= 1'b0;
            rgb_out_q   <= '0;
            rgb_valid_q <= 1'b0;
            win_idx_q   <= '0;
            win_valid_q <= 1'b0;
            acc_q       <= '0;
            frame_col_q <= '0;
            strobe_q    <= 1'b0;
        end else begin
            s1_eff_q    <= s1_eff_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_bg_q     <= s1_bg_d;
            s1_valid_q  <= s1_valid_d;
            rgb_out_q   <= rgb_out_d;
            rgb_valid_q <= rgb_valid_d;
            win_idx_q   <= win_idx_d;
            win_valid_q <= win_valid_d;
            acc_q       <= acc_d;
            frame_col_q <= frame_col_d;
            strobe_q    <= strobe_d;
        end
    end

    assign RGBOut               = rgb_out_q;
    assign RGBValid             = rgb_valid_q;
    assign winnerIdx            = win_idx_q;
    assign winnerValid          = win_valid_q;
    assign frameCollision       = frame_col_q;
    assign frameCollisionStrobe = strobe_q;

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    typedef struct {
        logic [7:0] rgb;
        logic [2:0] idx;
        logic       wv;
        int         due;
    } exp_t;

    logic            clk = 1'b0;
    logic            resetN;
    logic            pixelValid;
    logic            startOfFrame;
    logic [7:0]      layerEnable;
    logic [7:0]      layerDR;
    logic [7:0][7:0] layerRGB;
    logic [7:0]      backGroundRGB;
    logic [7:0]      RGBOut;
    logic            RGBValid;
    logic [2:0]      winnerIdx;
    logic            winnerValid;
    logic [7:0]      frameCollision;
    logic            frameCollisionStrobe;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_cyc;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] prev_rgb;
    logic [2:0] prev_idx;
    logic       prev_wv;
    logic [7:0][7:0] base_rgb;

    layer_compositor #(
        .LAYERS(8),
        .COLOR_W(8),
        .TRANSPARENT(8'hFF),
        .IDX_W(3)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .pixelValid(pixelValid),
        .startOfFrame(startOfFrame),
        .layerEnable(layerEnable),
        .layerDR(layerDR),
        .layerRGB(layerRGB),
        .backGroundRGB(backGroundRGB),
        .RGBOut(RGBOut),
        .RGBValid(RGBValid),
        .winnerIdx(winnerIdx),
        .winnerValid(winnerValid),
        .frameCollision(frameCollision),
        .frameCollisionStrobe(frameCollisionStrobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [7:0] en, input logic [7:0] dr,
                                   input logic [7:0][7:0] rgb, input logic [7:0] bg);
        exp_t e;
        e.rgb = bg;
        e.idx = 3'd0;
        e.wv  = 1'b0;
        e.due = 0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i] && dr[i] && rgb[i] !== 8'hFF) begin
                e.rgb = rgb[i];
                e.idx = 3'(i);
                e.wv  = 1'b1;
            end
        end
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge; valid pixels go to the scoreboard.
    task automatic drive_pixel(input logic v, input logic sof, input logic [7:0] en,
                               input logic [7:0] dr, input logic [7:0][7:0] rgb,
                               input logic [7:0] bg);
        exp_t e;
        @(negedge clk);
        pixelValid    = v;
        startOfFrame  = sof;
        layerEnable   = en;
        layerDR       = dr;
        layerRGB      = rgb;
        backGroundRGB = bg;
        last_cyc      = cyc;
        if (v) begin
            e     = model(en, dr, rgb, bg);
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic drive_idle();
        drive_pixel(1'b0, 1'b0, 8'hFF, 8'h00, base_rgb, 8'h00);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: pops on every valid output; bubbles must hold the outputs.
    always @(posedge clk) begin
        #1;
        if (mon_en && resetN) begin
            checks++;
            if (RGBValid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: RGBOut=%h at cycle %0d, none expected", RGBOut, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (RGBOut !== mon_e.rgb || winnerIdx !== mon_e.idx ||
                        winnerValid !== mon_e.wv || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL pixel: got rgb=%h idx=%0d wv=%b cyc=%0d, expected rgb=%h idx=%0d wv=%b cyc=%0d",
                                 RGBOut, winnerIdx, winnerValid, cyc,
                                 mon_e.rgb, mon_e.idx, mon_e.wv, mon_e.due);
                    end
                end
            end else begin
                if (RGBOut !== prev_rgb || winnerIdx !== prev_idx || winnerValid !== prev_wv) begin
                    errors++;
                    $display("FAIL bubble_hold: got rgb=%h idx=%0d wv=%b, expected held rgb=%h idx=%0d wv=%b",
                             RGBOut, winnerIdx, winnerValid, prev_rgb, prev_idx, prev_wv);
                end
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pixel: expected rgb=%h due cycle %0d, not seen by %0d",
                         sb[0].rgb, sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
        prev_rgb = RGBOut;
        prev_idx = winnerIdx;
        prev_wv  = winnerValid;
    end

    task automatic test_reset();
        int k;
        resetN = 1'b1;
        drive_idle();
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (RGBOut !== 8'h00 || RGBValid !== 1'b0 || winnerIdx !== 3'd0 ||
            winnerValid !== 1'b0 || frameCollision !== 8'h00 || frameCollisionStrobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rgb=%h v=%b idx=%0d wv=%b fc=%h st=%b, expected all zero",
                     RGBOut, RGBValid, winnerIdx, winnerValid, frameCollision, frameCollisionStrobe);
        end
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        mon_en = 1'b1;
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_1000, base_rgb, 8'h42);
        k = last_cyc;
        drive_idle();
        wait_until(k + 1);
        checks++;
        if (RGBValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_latency_early: RGBValid=%b at t+1, expected 0", RGBValid);
        end
        wait_until(k + 2);
        checks++;
        if (RGBValid !== 1'b1 || RGBOut !== 8'h13) begin
            errors++;
            $display("FAIL reset_latency: RGBValid=%b RGBOut=%h at t+2, expected 1 and 13", RGBValid, RGBOut);
        end
    endtask

    task automatic test_priority();
        logic [7:0][7:0] rgb;
        int k;
        rgb    = base_rgb;
        rgb[2] = 8'h1C;
        rgb[5] = 8'hE0;
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b1010_0100, rgb, 8'h42);
        k = last_cyc;
        drive_idle();
        wait_until(k + 2);
        checks++;
        if (RGBOut !== 8'h1C || winnerIdx !== 3'd2 || winnerValid !== 1'b1) begin
            errors++;
            $display("FAIL priority: rgb=%h idx=%0d wv=%b, expected 1c 2 1", RGBOut, winnerIdx, winnerValid);
        end
    endtask

    task automatic test_transparency_enable();
        logic [7:0][7:0] rgb;
        int k;
        rgb    = base_rgb;
        rgb[2] = 8'hFF;
        rgb[5] = 8'hE0;
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b1010_0100, rgb, 8'h42);
        k = last_cyc;
        drive_pixel(1'b1, 1'b0, 8'b0101_1111, 8'b1010_0100, rgb, 8'h42);
        drive_idle();
        wait_until(k + 2);
        checks++;
        if (RGBOut !== 8'hE0 || winnerIdx !== 3'd5 || winnerValid !== 1'b1) begin
            errors++;
            $display("FAIL transparent: rgb=%h idx=%0d wv=%b, expected e0 5 1", RGBOut, winnerIdx, winnerValid);
        end
        wait_until(k + 3);
        checks++;
        if (RGBOut !== 8'h42 || winnerIdx !== 3'd0 || winnerValid !== 1'b0) begin
            errors++;
            $display("FAIL disabled_to_bg: rgb=%h idx=%0d wv=%b, expected 42 0 0", RGBOut, winnerIdx, winnerValid);
        end
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'h00, rgb, 8'h5D);
        k = last_cyc;
        drive_idle();
        wait_until(k + 2);
        checks++;
        if (RGBOut !== 8'h5D || winnerValid !== 1'b0) begin
            errors++;
            $display("FAIL all_dr_low: rgb=%h wv=%b, expected 5d 0", RGBOut, winnerValid);
        end
    endtask

    task automatic test_bubble();
        logic [7:0][7:0] rgb;
        int k;
        rgb    = base_rgb;
        rgb[3] = 8'h33;
        rgb[1] = 8'h5A;
        rgb[6] = 8'h6C;
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_1000, rgb, 8'h00);
        k = last_cyc;
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_0010, rgb, 8'h00);
        wait_until(k + 2);
        checks++;
        if (RGBOut !== 8'h33 || RGBValid !== 1'b1) begin
            errors++;
            $display("FAIL bubble_a: rgb=%h v=%b, expected 33 1", RGBOut, RGBValid);
        end
        drive_pixel(1'b0, 1'b0, 8'hFF, 8'b0100_0000, rgb, 8'h00);
        wait_until(k + 3);
        checks++;
        if (RGBOut !== 8'h5A || RGBValid !== 1'b1) begin
            errors++;
            $display("FAIL bubble_b: rgb=%h v=%b, expected 5a 1", RGBOut, RGBValid);
        end
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0100_0000, rgb, 8'h00);
        wait_until(k + 4);
        checks++;
        if (RGBOut !== 8'h5A || RGBValid !== 1'b0 || winnerIdx !== 3'd1) begin
            errors++;
            $display("FAIL bubble_held: rgb=%h v=%b idx=%0d, expected 5a 0 1", RGBOut, RGBValid, winnerIdx);
        end
        drive_idle();
        wait_until(k + 5);
        checks++;
        if (RGBOut !== 8'h6C || RGBValid !== 1'b1 || winnerIdx !== 3'd6) begin
            errors++;
            $display("FAIL bubble_c: rgb=%h v=%b idx=%0d, expected 6c 1 6", RGBOut, RGBValid, winnerIdx);
        end
    endtask

    task automatic test_collision_frames();
        logic [7:0][7:0] rgb;
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL strobe_frame0: strobe=%b, expected 1", frameCollisionStrobe);
        end
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_1010, base_rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0001_0000, base_rgb, 8'h00);
        drive_idle();
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0000_1010 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL frame1_collision: fc=%b st=%b, expected 00001010 1", frameCollision, frameCollisionStrobe);
        end
        drive_idle();
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0000_1010 || frameCollisionStrobe !== 1'b0) begin
            errors++;
            $display("FAIL frame1_hold: fc=%b st=%b, expected 00001010 0", frameCollision, frameCollisionStrobe);
        end
        // Frame 2: invalid overlap, disabled partner, transparent partner, single layer.
        rgb    = base_rgb;
        rgb[5] = 8'hFF;
        drive_pixel(1'b0, 1'b0, 8'hFF, 8'b0000_0011, base_rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'b1111_0111, 8'b0000_1010, base_rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0010_0001, rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0100_0000, base_rgb, 8'h00);
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'h00 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL frame2_clear: fc=%b st=%b, expected 00000000 1", frameCollision, frameCollisionStrobe);
        end
        drive_idle();
    endtask

    task automatic test_sof_collision();
        drive_pixel(1'b1, 1'b1, 8'hFF, 8'b0100_0001, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'h00 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL sof_excluded: fc=%b st=%b, expected 00000000 1", frameCollision, frameCollisionStrobe);
        end
        drive_idle();
        drive_idle();
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0100_0001) begin
            errors++;
            $display("FAIL sof_reported: fc=%b, expected 01000001", frameCollision);
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        drive_pixel(1'b1, 1'b1, 8'hFF, 8'b0000_1100, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'h00 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: fc=%b st=%b, expected 00000000 1", frameCollision, frameCollisionStrobe);
        end
        drive_pixel(1'b1, 1'b1, 8'hFF, 8'b0011_0000, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0000_1100 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: fc=%b st=%b, expected 00001100 1", frameCollision, frameCollisionStrobe);
        end
        drive_idle();
        @(posedge clk); #1;
        checks++;
        if (frameCollisionStrobe !== 1'b0) begin
            errors++;
            $display("FAIL b2b_strobe_end: st=%b, expected 0", frameCollisionStrobe);
        end
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0011_0000) begin
            errors++;
            $display("FAIL b2b_third: fc=%b, expected 00110000", frameCollision);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_0110, base_rgb, 8'h00);
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'b0000_0110) begin
            errors++;
            $display("FAIL pre_reset_fc: fc=%b, expected 00000110", frameCollision);
        end
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b0000_0110, base_rgb, 8'h00);
        drive_pixel(1'b1, 1'b0, 8'hFF, 8'b1000_0000, base_rgb, 8'h00);
        drive_idle();
        resetN = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (RGBOut !== 8'h00 || RGBValid !== 1'b0 || winnerIdx !== 3'd0 || frameCollision !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: rgb=%h v=%b idx=%0d fc=%b, expected all zero",
                     RGBOut, RGBValid, winnerIdx, frameCollision);
        end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        drive_pixel(1'b0, 1'b1, 8'hFF, 8'h00, base_rgb, 8'h00);
        @(posedge clk); #1;
        checks++;
        if (frameCollision !== 8'h00 || frameCollisionStrobe !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_publish: fc=%b st=%b, expected 00000000 1", frameCollision, frameCollisionStrobe);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [7:0][7:0] rgb;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) begin
                rgb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            drive_pixel(1'($urandom_range(0, 3) != 0), 1'b0, 8'($urandom) | 8'hC3,
                        8'($urandom) & 8'($urandom), rgb, 8'($urandom));
        end
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) base_rgb[i] = 8'(8'h10 + i);
        resetN        = 1'b1;
        pixelValid    = 1'b0;
        startOfFrame  = 1'b0;
        layerEnable   = 8'hFF;
        layerDR       = 8'h00;
        layerRGB      = base_rgb;
        backGroundRGB = 8'h00;
        test_reset();
        test_priority();
        test_transparency_enable();
        test_bubble();
        test_random();
        test_collision_frames();
        test_sof_collision();
        test_back_to_back();
        test_reset_mid();
        wait_until(cyc + 4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
